lamp_sequence_ctrl: RTL and testbench



---
 rtl/lamp_sequence_ctrl_if.sv | 24 ++
 rtl/lamp_sequence_ctrl.sv | 152 +++++++++++++++
 tb/tb_lamp_sequence_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lamp_sequence_ctrl_if.sv
// Request inputs and lamp/status outputs of the four-lamp indicator sequencer.
// Lamps are active-low; mode encodes IDLE/RIGHT/LEFT/HAZARD as 00/01/10/11.
interface lamp_sequence_ctrl_if;
  logic       left_req;
  logic       right_req;
  logic       hazard;
  logic       L;
  logic       LC;
  logic       RC;
  logic       R;
  logic [1:0] mode;
  logic [1:0] step;
  logic       busy;

  modport master (
    output left_req, right_req, hazard,
    input  L, LC, RC, R, mode, step, busy
  );

  modport slave (
    input  left_req, right_req, hazard,
    output L, LC, RC, R, mode, step, busy
  );
endinterface

// File: rtl/lamp_sequence_ctrl.sv
// Turn/hazard sequencer for the L/LC/RC/R lamp bank with a TICK_DIV-cycle step prescaler.
// Every output is a flop whose next value is decoded from the next mode/step, so lamps change on the same edge as mode.
module lamp_sequence_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  lamp_sequence_ctrl_if.slave bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_LEFT   = 2'b10;
  localparam logic [1:0] MODE_HAZARD = 2'b11;

  localparam logic GRANT_LEFT  = 1'b0;
  localparam logic GRANT_RIGHT = 1'b1;

  // Lamp vectors are {L, LC, RC, R}, active-low.
  localparam logic [3:0] LAMPS_OFF  = 4'b1111;
  localparam logic [3:0] LAMPS_ALL  = 4'b0000;
  localparam logic [3:0] LAMPS_RC   = 4'b1101;
  localparam logic [3:0] LAMPS_RCR  = 4'b1100;
  localparam logic [3:0] LAMPS_LC   = 4'b1011;
  localparam logic [3:0] LAMPS_LCL  = 4'b0011;

  logic [1:0]    mode_q, mode_d;
  logic [1:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic [3:0]    lamps_q, lamps_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic [CW-1:0] cnt_next;

  assign tick     = (cnt_q == CNT_MAX);
  assign cnt_next = tick ? '0 : cnt_q + CW'(1);

  always_comb begin
    mode_d       = mode_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;

    case (mode_q)
      MODE_IDLE: begin
        cnt_d  = '0;
        step_d = 2'd0;
        if (bus.hazard) begin
          mode_d = MODE_HAZARD;
        end else if (bus.left_req && bus.right_req) begin
          // Tie: alternate away from whichever side was granted last.
          if (last_grant_q == GRANT_LEFT) begin
            mode_d       = MODE_RIGHT;
            last_grant_d = GRANT_RIGHT;
          end else begin
            mode_d       = MODE_LEFT;
            last_grant_d = GRANT_LEFT;
          end
        end else if (bus.left_req) begin
          mode_d       = MODE_LEFT;
          last_grant_d = GRANT_LEFT;
        end else if (bus.right_req) begin
          mode_d       = MODE_RIGHT;
          last_grant_d = GRANT_RIGHT;
        end
      end

      MODE_RIGHT, MODE_LEFT: begin
        if (bus.hazard) begin
          mode_d = MODE_HAZARD;
          step_d = 2'd0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_next;
          if (tick) begin
            if (step_q == 2'd2) begin
              mode_d = MODE_IDLE;
              step_d = 2'd0;
            end else begin
              step_d = step_q + 2'd1;
            end
          end
        end
      end

      default: begin
        cnt_d = cnt_next;
        if (tick) begin
          if (step_q == 2'd0) begin
            step_d = 2'd1;
          end else if (bus.hazard) begin
            step_d = 2'd0;
          end else begin
            mode_d = MODE_IDLE;
            step_d = 2'd0;
          end
        end
      end
    endcase
  end

  always_comb begin
    lamps_d = LAMPS_OFF;
    case (mode_d)
      MODE_RIGHT: begin
        if (step_d == 2'd0)      lamps_d = LAMPS_RC;
        else if (step_d == 2'd1) lamps_d = LAMPS_RCR;
      end
      MODE_LEFT: begin
        if (step_d == 2'd0)      lamps_d = LAMPS_LC;
        else if (step_d == 2'd1) lamps_d = LAMPS_LCL;
      end
      MODE_HAZARD: begin
        if (step_d == 2'd0)      lamps_d = LAMPS_ALL;
      end
      default: lamps_d = LAMPS_OFF;
    endcase
    busy_d = (mode_d != MODE_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_IDLE;
      step_q       <= 2'd0;
      cnt_q        <= '0;
      last_grant_q <= GRANT_LEFT;
      lamps_q      <= LAMPS_OFF;
      busy_q       <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      lamps_q      <= lamps_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.L    = lamps_q[3];
  assign bus.LC   = lamps_q[2];
  assign bus.RC   = lamps_q[1];
  assign bus.R    = lamps_q[0];
  assign bus.mode = mode_q;
  assign bus.step = step_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_lamp_sequence_ctrl.sv
// Directed bench for lamp_sequence_ctrl: a TICK_DIV=4 instance driven from a vector table and
// hand sequences, plus a TICK_DIV=1 instance for the single-cycle-step corner.
module tb_lamp_sequence_ctrl;

  logic clk;
  logic reset;

  lamp_sequence_ctrl_if bus4 ();
  lamp_sequence_ctrl_if bus1 ();

  lamp_sequence_ctrl #(.TICK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  lamp_sequence_ctrl #(.TICK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic       r;
    logic       h;
    logic [3:0] lamps;
    logic [1:0] mode;
    logic [1:0] step;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void add(int n, logic l, logic r, logic h,
                              logic [3:0] lamps, logic [1:0] mode, logic [1:0] step);
    for (int i = 0; i < n; i++) vecs.push_back('{l, r, h, lamps, mode, step});
  endfunction

  // Packed view: {L, LC, RC, R, mode, step, busy}
  function automatic logic [8:0] expv(logic [3:0] lamps, logic [1:0] mode, logic [1:0] step);
    return {lamps, mode, step, (mode != 2'b00)};
  endfunction

  function automatic logic [8:0] obs4();
    return {bus4.L, bus4.LC, bus4.RC, bus4.R, bus4.mode, bus4.step, bus4.busy};
  endfunction

  function automatic logic [8:0] obs1();
    return {bus1.L, bus1.LC, bus1.RC, bus1.R, bus1.mode, bus1.step, bus1.busy};
  endfunction

  // Expected lamps for a turn: dir 1 = RIGHT, 2 = LEFT.
  function automatic logic [3:0] turn_lamps(logic [1:0] dir, int s);
    if (s == 2) return 4'b1111;
    if (dir == 2'b01) return (s == 0) ? 4'b1101 : 4'b1100;
    return (s == 0) ? 4'b1011 : 4'b0011;
  endfunction

  task automatic check(string nm, logic [8:0] act, logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got lamps/mode/step/busy=%b required %b", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus4.left_req = 0; bus4.right_req = 0; bus4.hazard = 0;
    bus1.left_req = 0; bus1.right_req = 0; bus1.hazard = 0;
    reset = 1'b1;

    // Single right pulse: 4 cycles RC, 4 cycles RC+R, 4 dark, then IDLE.
    add(1, 0, 0, 0, 4'b1111, 2'b00, 2'd0);
    add(1, 0, 1, 0, 4'b1101, 2'b01, 2'd0);
    add(3, 0, 0, 0, 4'b1101, 2'b01, 2'd0);
    add(4, 0, 0, 0, 4'b1100, 2'b01, 2'd1);
    add(4, 0, 0, 0, 4'b1111, 2'b01, 2'd2);
    add(1, 0, 0, 0, 4'b1111, 2'b00, 2'd0);
    // Hazard beats right_req; held right_req is served only after hazard exits.
    add(1, 0, 1, 1, 4'b0000, 2'b11, 2'd0);
    add(3, 0, 1, 0, 4'b0000, 2'b11, 2'd0);
    add(4, 0, 1, 0, 4'b1111, 2'b11, 2'd1);
    add(1, 0, 1, 0, 4'b1111, 2'b00, 2'd0);
    add(1, 0, 1, 0, 4'b1101, 2'b01, 2'd0);
    // Hazard pre-empts RIGHT step 0, turn abandoned.
    add(1, 0, 0, 1, 4'b0000, 2'b11, 2'd0);
    add(3, 0, 0, 0, 4'b0000, 2'b11, 2'd0);
    add(4, 0, 0, 0, 4'b1111, 2'b11, 2'd1);
    add(2, 0, 0, 0, 4'b1111, 2'b00, 2'd0);

    #2;
    check("reset4", obs4(), expv(4'b1111, 2'b00, 2'd0));
    check("reset1", obs1(), expv(4'b1111, 2'b00, 2'd0));
    #10 reset = 1'b0;

    foreach (vecs[i]) begin
      bus4.left_req  = vecs[i].l;
      bus4.right_req = vecs[i].r;
      bus4.hazard    = vecs[i].h;
      cyc();
      check($sformatf("vec%0d", i), obs4(), expv(vecs[i].lamps, vecs[i].mode, vecs[i].step));
    end

    // Asynchronous reset in the middle of a right sequence, checked before any edge.
    bus4.right_req = 1; cyc();
    bus4.right_req = 0; cyc(); cyc(); cyc(); cyc(); cyc();
    check("pre_async_reset", obs4(), expv(4'b1100, 2'b01, 2'd1));
    #3 reset = 1'b1;
    #1 check("async_reset", obs4(), expv(4'b1111, 2'b00, 2'd0));
    #2 reset = 1'b0;

    // Held tie from reset alternates RIGHT, LEFT, RIGHT with one IDLE cycle between runs.
    bus4.left_req = 1; bus4.right_req = 1;
    for (int run = 0; run < 3; run++) begin
      logic [1:0] dir;
      dir = (run % 2 == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k <= 12; k++) begin
        if (run == 2 && k == 12) begin
          bus4.left_req = 0; bus4.right_req = 0;
        end
        cyc();
        if (k < 12)
          check($sformatf("tie_r%0d_k%0d", run, k), obs4(), expv(turn_lamps(dir, k / 4), dir, 2'(k / 4)));
        else
          check($sformatf("tie_r%0d_idle", run), obs4(), expv(4'b1111, 2'b00, 2'd0));
      end
    end
    cyc();
    check("tie_done_idle", obs4(), expv(4'b1111, 2'b00, 2'd0));

    // Hazard raised in LEFT step 1, held through two toggles, dropped mid all-on step.
    bus4.left_req = 1; cyc();
    check("left_entry", obs4(), expv(4'b1011, 2'b10, 2'd0));
    bus4.left_req = 0;
    cyc(); cyc(); cyc(); cyc();
    check("left_step1", obs4(), expv(4'b0011, 2'b10, 2'd1));
    bus4.hazard = 1; cyc();
    check("haz_preempt", obs4(), expv(4'b0000, 2'b11, 2'd0));
    for (int k = 1; k <= 16; k++) begin
      bus4.hazard = (k <= 9);
      cyc();
      if (k == 16)
        check("haz_exit", obs4(), expv(4'b1111, 2'b00, 2'd0));
      else if ((k / 4) % 2 == 0)
        check($sformatf("haz_k%0d", k), obs4(), expv(4'b0000, 2'b11, 2'd0));
      else
        check($sformatf("haz_k%0d", k), obs4(), expv(4'b1111, 2'b11, 2'd1));
    end

    // TICK_DIV = 1: one cycle per step.
    bus1.left_req = 1; cyc();
    check("t1_left_s0", obs1(), expv(4'b1011, 2'b10, 2'd0));
    bus1.left_req = 0; cyc();
    check("t1_left_s1", obs1(), expv(4'b0011, 2'b10, 2'd1));
    cyc();
    check("t1_left_s2", obs1(), expv(4'b1111, 2'b10, 2'd2));
    cyc();
    check("t1_idle", obs1(), expv(4'b1111, 2'b00, 2'd0));
    bus1.left_req = 1; bus1.right_req = 1; cyc();
    check("t1_tie_right", obs1(), expv(4'b1101, 2'b01, 2'd0));
    bus1.left_req = 0; bus1.right_req = 0; cyc();
    check("t1_right_s1", obs1(), expv(4'b1100, 2'b01, 2'd1));
    bus1.hazard = 1; cyc();
    check("t1_haz_s0", obs1(), expv(4'b0000, 2'b11, 2'd0));
    bus1.hazard = 0; cyc();
    check("t1_haz_s1", obs1(), expv(4'b1111, 2'b11, 2'd1));
    cyc();
    check("t1_haz_exit", obs1(), expv(4'b1111, 2'b00, 2'd0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
